// File: rtl/imu_poll_scheduler.sv
// rtl/imu_poll_scheduler.sv - periodic IMU poll sequencer with coherent snapshot, watchdog and health counters
module imu_poll_scheduler #(
    parameter int PERIOD_CYCLES  = 500000,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic         clear_err,
    output logic         imu_start,
    input  logic         imu_done,
    input  logic [143:0] imu_data,
    output logic [143:0] snapshot,
    output logic         sample_valid,
    output logic         busy,
    output logic         timeout_err,
    output logic [15:0]  sample_count,
    output logic [7:0]   err_count,
    output logic [7:0]   overrun_count
);

    localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [PW-1:0] period_cnt;
    logic [TW-1:0] timeout_cnt;
    logic          tick;
    logic          capture;
    logic          expire;
    logic          overrun_inc;
    logic [7:0]    err_base;
    logic [7:0]    ovr_base;

    assign tick        = enable && (period_cnt == PW'(PERIOD_CYCLES - 1));
    assign overrun_inc = tick && (state != S_IDLE);

    // The period counter free-runs through transactions so polls stay on a fixed grid.
    always_ff @(posedge clock) begin
        if (reset || !enable || tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        imu_start = 1'b0;
        busy      = 1'b0;
        capture   = 1'b0;
        expire    = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick) begin
                    state_n = S_START;
                end
            end
            S_START: begin
                imu_start = 1'b1;
                busy      = 1'b1;
                state_n   = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                // A done on the expiry cycle still counts as a good capture.
                if (imu_done) begin
                    capture = 1'b1;
                    state_n = S_IDLE;
                end else if (timeout_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    expire  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || state == S_START) begin
            timeout_cnt <= '0;
        end else if (state == S_WAIT && !imu_done && !expire) begin
            timeout_cnt <= timeout_cnt + TW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            snapshot     <= '0;
            sample_valid <= 1'b0;
            sample_count <= '0;
        end else begin
            sample_valid <= capture;
            if (capture) begin
                snapshot     <= imu_data;
                sample_count <= sample_count + 16'd1;
            end
        end
    end

    // Clear is applied first so a coincident new event still lands in the counters.
    always_comb begin
        err_base = clear_err ? 8'd0 : err_count;
        ovr_base = clear_err ? 8'd0 : overrun_count;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_err   <= 1'b0;
            err_count     <= '0;
            overrun_count <= '0;
        end else begin
            if (expire) begin
                timeout_err <= 1'b1;
            end else if (clear_err) begin
                timeout_err <= 1'b0;
            end
            err_count     <= (expire && err_base != 8'd255) ? err_base + 8'd1 : err_base;
            overrun_count <= (overrun_inc && ovr_base != 8'd255) ? ovr_base + 8'd1 : ovr_base;
        end
    end

endmodule

// File: tb/tb_imu_poll_scheduler.sv
// tb/tb_imu_poll_scheduler.sv - scoreboard bench for imu_poll_scheduler
module tb_imu_poll_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_a, enable_a, clear_a, done_a;
    logic [143:0] data_a;
    logic         start_a, sv_a, busy_a, terr_a;
    logic [143:0] snap_a;
    logic [15:0]  scnt_a;
    logic [7:0]   ecnt_a, ocnt_a;

    logic         reset_b, enable_b, clear_b, done_b;
    logic [143:0] data_b;
    logic         start_b, sv_b, busy_b, terr_b;
    logic [143:0] snap_b;
    logic [15:0]  scnt_b;
    logic [7:0]   ecnt_b, ocnt_b;

    imu_poll_scheduler #(.PERIOD_CYCLES(100), .TIMEOUT_CYCLES(40)) dut_a (
        .clock(clk), .reset(reset_a), .enable(enable_a), .clear_err(clear_a),
        .imu_start(start_a), .imu_done(done_a), .imu_data(data_a),
        .snapshot(snap_a), .sample_valid(sv_a), .busy(busy_a), .timeout_err(terr_a),
        .sample_count(scnt_a), .err_count(ecnt_a), .overrun_count(ocnt_a)
    );

    imu_poll_scheduler #(.PERIOD_CYCLES(50), .TIMEOUT_CYCLES(49)) dut_b (
        .clock(clk), .reset(reset_b), .enable(enable_b), .clear_err(clear_b),
        .imu_start(start_b), .imu_done(done_b), .imu_data(data_b),
        .snapshot(snap_b), .sample_valid(sv_b), .busy(busy_b), .timeout_err(terr_b),
        .sample_count(scnt_b), .err_count(ecnt_b), .overrun_count(ocnt_b)
    );

    int           n_checks = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           resp_delay = 0;
    bit           suppress = 1'b0;
    int           pay_k = 0;
    int           sv_a_cnt = 0;
    int           sv_b_cnt = 0;
    logic [143:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [143:0] payload(input int k);
        logic [143:0] d;
        for (int i = 0; i < 9; i++) begin
            d[i*16 +: 16] = 16'((k << 8) | (i + 1));
        end
        return d;
    endfunction

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_start(input int budget, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            n++;
            if (start_a) seen = 1'b1;
        end
        chki("start_seen", int'(seen), 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_snapshot"}, snap_a, '0);
        chki({tag, "_sample_valid"}, int'(sv_a), 0);
        chki({tag, "_imu_start"}, int'(start_a), 0);
        chki({tag, "_busy"}, int'(busy_a), 0);
        chki({tag, "_timeout_err"}, int'(terr_a), 0);
        chki({tag, "_sample_count"}, int'(scnt_a), 0);
        chki({tag, "_err_count"}, int'(ecnt_a), 0);
        chki({tag, "_overrun_count"}, int'(ocnt_a), 0);
    endtask

    // IMU reader model: answers each start after resp_delay cycles (0 = never).
    initial begin
        done_a = 1'b0;
        data_a = '0;
        forever begin
            @(negedge clk);
            if (start_a && resp_delay > 0) begin
                repeat (resp_delay) @(negedge clk);
                done_a = 1'b1;
                data_a = payload(pay_k);
                if (!suppress) exp_q.push_back(data_a);
                pay_k++;
                @(negedge clk);
                done_a = 1'b0;
                data_a = '0;
            end
        end
    end

    // Monitor: every sample_valid must match the oldest expected snapshot.
    always @(negedge clk) begin
        if (sv_a) begin
            sv_a_cnt++;
            if (exp_q.size() == 0) begin
                chki("sample_valid_unexpected", int'(sv_a), 0);
            end else begin
                chk("snapshot_scoreboard", snap_a, exp_q.pop_front());
            end
        end
        if (sv_b) sv_b_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

    initial begin
        int n, t_start, nb, svc, starts;
        bit seen_b;
        reset_a = 1'b1; enable_a = 1'b0; clear_a = 1'b0;
        reset_b = 1'b1; enable_b = 1'b0; clear_b = 1'b0;
        done_b = 1'b0; data_b = '0;
        repeat (3) @(negedge clk);
        reset_a = 1'b0;
        reset_b = 1'b0;
        check_zero("reset");

        // Normal capture, done 20 cycles after start
        resp_delay = 20;
        enable_a = 1'b1;
        wait_start(200, n);
        chki("first_start_latency", n, 100);
        t_start = cyc;
        @(negedge clk);
        chki("start_width", int'(start_a), 0);
        repeat (30) @(negedge clk);
        chk("snapshot_t1", snap_a, payload(0));
        chki("sample_count_t1", int'(scnt_a), 1);
        chki("busy_after_t1", int'(busy_a), 0);
        chki("sample_valid_pulses_t1", sv_a_cnt, 1);

        // No done: timeout
        resp_delay = 0;
        wait_start(200, n);
        chki("period_gap_t2", cyc - t_start, 100);
        t_start = cyc;
        nb = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy_a) nb++;
        end
        chki("busy_cycles_timeout", nb, 40);
        chki("timeout_err_t2", int'(terr_a), 1);
        chki("err_count_t2", int'(ecnt_a), 1);
        chk("snapshot_kept_t2", snap_a, payload(0));
        chki("sample_count_t2", int'(scnt_a), 1);
        chki("sample_valid_pulses_t2", sv_a_cnt, 1);

        // Isolated clear
        clear_a = 1'b1;
        @(negedge clk);
        clear_a = 1'b0;
        chki("clear_timeout_err", int'(terr_a), 0);
        chki("clear_err_count", int'(ecnt_a), 0);
        chki("clear_overrun_count", int'(ocnt_a), 0);

        // Done coincident with timeout expiry
        resp_delay = 40;
        wait_start(100, n);
        chki("period_gap_t3", cyc - t_start, 100);
        repeat (45) @(negedge clk);
        chk("snapshot_coincident", snap_a, payload(1));
        chki("sample_count_coincident", int'(scnt_a), 2);
        chki("timeout_err_coincident", int'(terr_a), 0);
        chki("err_count_coincident", int'(ecnt_a), 0);

        // clear_err on the same cycle as a timeout
        resp_delay = 0;
        wait_start(100, n);
        repeat (40) @(negedge clk);
        clear_a = 1'b1;
        @(negedge clk);
        clear_a = 1'b0;
        chki("set_wins_timeout_err", int'(terr_a), 1);
        chki("set_wins_err_count", int'(ecnt_a), 1);
        @(negedge clk);
        clear_a = 1'b1;
        @(negedge clk);
        clear_a = 1'b0;
        chki("late_clear_timeout_err", int'(terr_a), 0);
        chki("late_clear_err_count", int'(ecnt_a), 0);
        chki("late_clear_overrun", int'(ocnt_a), 0);

        // Reset mid-WAIT, late done must be ignored
        resp_delay = 30;
        suppress = 1'b1;
        wait_start(100, n);
        repeat (10) @(negedge clk);
        reset_a = 1'b1;
        enable_a = 1'b0;
        repeat (2) @(negedge clk);
        reset_a = 1'b0;
        check_zero("reset_mid");
        svc = sv_a_cnt;
        repeat (40) @(negedge clk);
        chki("late_done_sample_count", int'(scnt_a), 0);
        chk("late_done_snapshot", snap_a, '0);
        chki("late_done_no_valid", sv_a_cnt, svc);
        suppress = 1'b0;
        resp_delay = 20;
        enable_a = 1'b1;
        wait_start(200, n);
        chki("restart_latency", n, 100);
        repeat (25) @(negedge clk);
        chk("snapshot_restart", snap_a, payload(3));
        chki("sample_count_restart", int'(scnt_a), 1);
        enable_a = 1'b0;

        // Overrun and saturation (PERIOD 50, TIMEOUT 49, never done)
        enable_b = 1'b1;
        seen_b = 1'b0;
        for (int i = 0; i < 80 && !seen_b; i++) begin
            @(negedge clk);
            if (start_b) seen_b = 1'b1;
        end
        chki("b_start_seen", int'(seen_b), 1);
        starts = 0;
        for (int i = 0; i < 99; i++) begin
            @(negedge clk);
            if (start_b) starts++;
        end
        chki("b_no_start_on_overrun", starts, 0);
        chki("b_overrun_count", int'(ocnt_b), 1);
        chki("b_err_count_first", int'(ecnt_b), 1);
        repeat (30000) @(negedge clk);
        chki("b_err_count_saturated", int'(ecnt_b), 255);
        chki("b_overrun_saturated", int'(ocnt_b), 255);
        chki("b_timeout_err", int'(terr_b), 1);
        chki("b_sample_count", int'(scnt_b), 0);
        chk("b_snapshot", snap_b, '0);
        chki("b_no_sample_valid", sv_b_cnt, 0);

        chki("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
